// File: rtl/wb_master_arbiter_if.sv
// Bundled Wishbone signals between the masters, the arbiter and the shared slave path.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [32*NUM_MASTERS-1:0] i_m_adr;
  logic [32*NUM_MASTERS-1:0] i_m_dat;
  logic [NUM_MASTERS-1:0]    i_m_we;
  logic [4*NUM_MASTERS-1:0]  i_m_sel;
  logic [NUM_MASTERS-1:0]    i_m_stb;
  logic [NUM_MASTERS-1:0]    i_m_cyc;
  logic [31:0]               o_m_dat;
  logic [NUM_MASTERS-1:0]    o_m_ack;
  logic [NUM_MASTERS-1:0]    o_m_err;
  logic [31:0]               o_s_adr;
  logic [31:0]               o_s_dat;
  logic [31:0]               i_s_dat;
  logic                      o_s_we;
  logic [3:0]                o_s_sel;
  logic                      o_s_stb;
  logic                      o_s_cyc;
  logic                      i_s_ack;
  logic [NUM_MASTERS-1:0]    o_grant;
  logic                      o_busy;

  modport master (
    input  i_m_adr, i_m_dat, i_m_we, i_m_sel, i_m_stb, i_m_cyc, i_s_dat, i_s_ack,
    output o_m_dat, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb,
           o_s_cyc, o_grant, o_busy
  );

  modport slave (
    output i_m_adr, i_m_dat, i_m_we, i_m_sel, i_m_stb, i_m_cyc, i_s_dat, i_s_ack,
    input  o_m_dat, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb,
           o_s_cyc, o_grant, o_busy
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter with a bus watchdog that terminates hung cycles.
module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input logic                 i_clk,
  input logic                 i_reset,
  wb_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  // Timeout fires when a stall is seen with the counter one below the limit,
  // so the error cycle lands exactly TIMEOUT_CYCLES cycles after stb rises.
  localparam logic [TO_WIDTH-1:0] WDOG_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  state_t                  state, state_next;
  logic [NUM_MASTERS-1:0]  r_grant, grant_next;
  logic [IDX_W-1:0]        r_idx, idx_next;
  logic [IDX_W-1:0]        r_last, last_next;
  logic [IDX_W-1:0]        pick_idx, cand_idx;
  logic                    pick_valid;
  int unsigned             cand;
  logic [TO_WIDTH-1:0]     wdog, wdog_next;
  logic                    g_cyc, g_stb, stall, timeout;

  assign g_cyc   = bus.i_m_cyc[r_idx];
  assign g_stb   = bus.i_m_stb[r_idx];
  assign stall   = g_stb & ~bus.i_s_ack;
  assign timeout = WDOG_EN && stall && (wdog == WDOG_LAST);

  // Round-robin pick: first requester scanning upward from the last owner, with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand     = (32'(r_last) + i + 1) % NUM_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && bus.i_m_cyc[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= LAST_IDX;
      wdog    <= '0;
    end else begin
      state   <= state_next;
      r_grant <= grant_next;
      r_idx   <= idx_next;
      r_last  <= last_next;
      wdog    <= wdog_next;
    end
  end

  // Next-state logic: grant on request, hold while cyc, watchdog error, release to IDLE.
  always_comb begin
    state_next = state;
    grant_next = r_grant;
    idx_next   = r_idx;
    last_next  = r_last;
    wdog_next  = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next           = BUSY;
          idx_next             = pick_idx;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_next = IDLE;
          last_next  = r_idx;
          grant_next = '0;
        end else if (timeout) begin
          state_next = ERR;
        end else if (WDOG_EN && stall) begin
          wdog_next = wdog + 1'b1;
        end
      end
      ERR: begin
        if (g_cyc) begin
          state_next = BUSY;
        end else begin
          state_next = IDLE;
          last_next  = r_idx;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Output mux: granted master drives the slave side; ack/err routed to it alone.
  always_comb begin
    bus.o_m_dat = bus.i_s_dat;
    bus.o_m_ack = '0;
    bus.o_m_err = '0;
    bus.o_s_adr = '0;
    bus.o_s_dat = '0;
    bus.o_s_we  = 1'b0;
    bus.o_s_sel = '0;
    bus.o_s_stb = 1'b0;
    bus.o_s_cyc = 1'b0;
    bus.o_grant = r_grant;
    bus.o_busy  = 1'b0;
    case (state)
      BUSY: begin
        bus.o_s_adr        = bus.i_m_adr[32*r_idx +: 32];
        bus.o_s_dat        = bus.i_m_dat[32*r_idx +: 32];
        bus.o_s_we         = bus.i_m_we[r_idx];
        bus.o_s_sel        = bus.i_m_sel[4*r_idx +: 4];
        bus.o_s_cyc        = g_cyc;
        bus.o_s_stb        = g_stb;
        bus.o_m_ack[r_idx] = bus.i_s_ack & g_stb;
        bus.o_busy         = 1'b1;
      end
      ERR: begin
        bus.o_s_adr        = bus.i_m_adr[32*r_idx +: 32];
        bus.o_s_dat        = bus.i_m_dat[32*r_idx +: 32];
        bus.o_s_we         = bus.i_m_we[r_idx];
        bus.o_s_sel        = bus.i_m_sel[4*r_idx +: 4];
        bus.o_s_cyc        = 1'b1;
        bus.o_m_err[r_idx] = 1'b1;
        bus.o_busy         = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (2 masters, 8-cycle watchdog).
module tb_wb_master_arbiter;

  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_master_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  wb_master_arbiter #(
    .NUM_MASTERS   (NM),
    .TIMEOUT_CYCLES(8),
    .TO_WIDTH      (4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.i_m_adr = '0;
    bus.i_m_dat = '0;
    bus.i_m_we  = '0;
    bus.i_m_sel = '0;
    bus.i_m_stb = '0;
    bus.i_m_cyc = '0;
    bus.i_s_dat = '0;
    bus.i_s_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    // Reset state
    check("rst_s_cyc", 32'(bus.o_s_cyc), 32'd0);
    check("rst_s_stb", 32'(bus.o_s_stb), 32'd0);
    check("rst_m_ack", 32'(bus.o_m_ack), 32'd0);
    check("rst_m_err", 32'(bus.o_m_err), 32'd0);
    check("rst_grant", 32'(bus.o_grant), 32'd0);
    check("rst_busy",  32'(bus.o_busy),  32'd0);
    rst = 1'b0;

    // Slave ack while IDLE must not reach any master
    bus.i_s_ack = 1'b1;
    #1;
    check("idle_ack_iso", 32'(bus.o_m_ack), 32'd0);
    check("idle_s_adr",   bus.o_s_adr,      32'd0);
    bus.i_s_ack = 1'b0;

    // Single master read with slave ack 2 cycles after stb
    bus.i_m_adr = {32'h0, 32'h1000_0000};
    bus.i_m_sel = 8'h0F;
    bus.i_m_cyc = 2'b01;
    bus.i_m_stb = 2'b01;
    #1;
    check("t1_grant_lat", 32'(bus.o_grant), 32'd0);
    check("t1_s_cyc_lat", 32'(bus.o_s_cyc), 32'd0);
    step();
    check("t1_grant", 32'(bus.o_grant), 32'd1);
    check("t1_s_cyc", 32'(bus.o_s_cyc), 32'd1);
    check("t1_s_stb", 32'(bus.o_s_stb), 32'd1);
    check("t1_s_adr", bus.o_s_adr, 32'h1000_0000);
    check("t1_s_sel", 32'(bus.o_s_sel), 32'hF);
    step();
    check("t1_wait_ack", 32'(bus.o_m_ack), 32'd0);
    step();
    bus.i_s_ack = 1'b1;
    bus.i_s_dat = 32'hCAFE_F00D;
    #1;
    check("t1_ack", 32'(bus.o_m_ack), 32'd1);
    check("t1_dat", bus.o_m_dat, 32'hCAFE_F00D);
    step();
    bus.i_s_ack = 1'b0;
    bus.i_m_cyc = 2'b00;
    bus.i_m_stb = 2'b00;
    #1;
    check("t1_drop_cyc", 32'(bus.o_s_cyc), 32'd0);
    step();
    check("t1_idle_busy",  32'(bus.o_busy),  32'd0);
    check("t1_idle_grant", 32'(bus.o_grant), 32'd0);

    // Contention: both request at reset release, grants alternate with an IDLE gap
    rst = 1'b1;
    clear_inputs();
    bus.i_m_adr = {32'h2000_0000, 32'h1000_0000};
    bus.i_m_cyc = 2'b11;
    bus.i_m_stb = 2'b11;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 2;
      check("cont_grant", 32'(bus.o_grant), 32'd1 << g);
      bus.i_s_ack = 1'b1;
      #1;
      check("cont_ack", 32'(bus.o_m_ack), 32'd1 << g);
      step();
      bus.i_s_ack    = 1'b0;
      bus.i_m_cyc[g] = 1'b0;
      bus.i_m_stb[g] = 1'b0;
      step();
      check("cont_gap", 32'(bus.o_grant), 32'd0);
      bus.i_m_cyc[g] = 1'b1;
      bus.i_m_stb[g] = 1'b1;
      step();
    end

    // Burst hold: M1 keeps the bus for 4 beats while M0 waits
    do_reset();
    bus.i_m_adr = {32'h2000_0040, 32'h1000_0000};
    bus.i_m_cyc = 2'b10;
    bus.i_m_stb = 2'b10;
    step();
    check("burst_grant", 32'(bus.o_grant), 32'd2);
    check("burst_adr",   bus.o_s_adr,      32'h2000_0040);
    bus.i_m_cyc = 2'b11;
    bus.i_m_stb = 2'b11;
    for (int b = 0; b < 4; b++) begin
      bus.i_s_ack = 1'b1;
      bus.i_s_dat = 32'(b);
      // Last beat: cyc drops together with the ack, which must still be delivered
      if (b == 3) bus.i_m_cyc[1] = 1'b0;
      #1;
      check("burst_ack",  32'(bus.o_m_ack), 32'd2);
      check("burst_hold", 32'(bus.o_grant), 32'd2);
      step();
    end
    check("burst_gap",      32'(bus.o_grant), 32'd0);
    check("burst_idle_ack", 32'(bus.o_m_ack), 32'd0);
    bus.i_s_ack    = 1'b0;
    bus.i_m_stb[1] = 1'b0;
    step();
    check("burst_m0_grant", 32'(bus.o_grant), 32'd1);
    bus.i_m_cyc = 2'b00;
    bus.i_m_stb = 2'b00;
    step();
    step();

    // Watchdog: no ack for 8 stb cycles yields one ERR cycle
    do_reset();
    bus.i_m_cyc = 2'b01;
    bus.i_m_stb = 2'b01;
    step();
    check("to_stb0", 32'(bus.o_s_stb), 32'd1);
    repeat (7) step();
    check("to_pre_err", 32'(bus.o_m_err), 32'd0);
    check("to_pre_stb", 32'(bus.o_s_stb), 32'd1);
    step();
    check("to_err",   32'(bus.o_m_err), 32'd1);
    check("to_stb",   32'(bus.o_s_stb), 32'd0);
    check("to_cyc",   32'(bus.o_s_cyc), 32'd1);
    check("to_busy",  32'(bus.o_busy),  32'd1);
    bus.i_s_ack = 1'b1;
    #1;
    check("err_ack_drop", 32'(bus.o_m_ack), 32'd0);
    step();
    bus.i_s_ack = 1'b0;
    #1;
    check("to_err_once", 32'(bus.o_m_err), 32'd0);
    check("to_rebusy",   32'(bus.o_s_stb), 32'd1);
    // Ack on the 8th stall cycle beats the timeout
    repeat (7) step();
    bus.i_s_ack = 1'b1;
    #1;
    check("to_ack8", 32'(bus.o_m_ack), 32'd1);
    step();
    bus.i_s_ack = 1'b0;
    #1;
    check("to_ack_wins", 32'(bus.o_m_err), 32'd0);
    check("to_ack_stb",  32'(bus.o_s_stb), 32'd1);
    bus.i_m_cyc = 2'b00;
    bus.i_m_stb = 2'b00;
    step();
    step();

    // Reset in the middle of an M1 transfer
    do_reset();
    bus.i_m_cyc = 2'b10;
    bus.i_m_stb = 2'b10;
    step();
    check("mr_grant", 32'(bus.o_grant), 32'd2);
    #3;
    bus.i_s_ack = 1'b1;
    #1;
    check("mr_pre_ack", 32'(bus.o_m_ack), 32'd2);
    rst = 1'b1;
    #1;
    check("mr_s_cyc", 32'(bus.o_s_cyc), 32'd0);
    check("mr_s_stb", 32'(bus.o_s_stb), 32'd0);
    check("mr_grant0", 32'(bus.o_grant), 32'd0);
    check("mr_m_ack", 32'(bus.o_m_ack), 32'd0);
    bus.i_s_ack = 1'b0;
    bus.i_m_cyc = 2'b11;
    bus.i_m_stb = 2'b11;
    step();
    rst = 1'b0;
    step();
    check("mr_restart", 32'(bus.o_grant), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone path into the main NIC between up to NUM_MASTERS bus masters, e.g. the rv_top_wb core and a firmware-loader/debug DMA.
- Sits between the masters and the nic/tcm/uart fabric.
- Multiplexes the granted master onto the slave side and routes ack back to that master only.
- Includes a bus watchdog that terminates hung cycles with an error.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT_CYCLES, 255, cycles of stb without ack before error termination; 0 disables the watchdog
- TO_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_m_adr  in  32*NUM_MASTERS  master addresses, master k at [k*32+:32]
- i_m_dat  in  32*NUM_MASTERS  master write data
- i_m_we  in  NUM_MASTERS  write enables
- i_m_sel  in  4*NUM_MASTERS  byte selects
- i_m_stb  in  NUM_MASTERS  strobes
- i_m_cyc  in  NUM_MASTERS  cycle requests
- o_m_dat  out  32  read data, broadcast to all masters
- o_m_ack  out  NUM_MASTERS  per-master ack
- o_m_err  out  NUM_MASTERS  per-master timeout error
- o_s_adr  out  32  slave address
- o_s_dat  out  32  slave write data
- i_s_dat  in  32  slave read data
- o_s_we  out  1  slave write enable
- o_s_sel  out  4  slave byte select
- o_s_stb  out  1  slave strobe
- o_s_cyc  out  1  slave cycle
- i_s_ack  in  1  slave ack
- o_grant  out  NUM_MASTERS  one-hot current grant (debug)
- o_busy  out  1  a master holds the bus

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE, r_grant=0, r_last=NUM_MASTERS-1, watchdog=0.
  - All outputs 0: o_s_cyc, o_s_stb, o_m_ack, o_m_err, o_grant, o_busy.
- IDLE:
  - o_s_cyc/o_s_stb=0; o_s_adr/dat/we/sel driven 0.
  - If any i_m_cyc=1, pick the first requesting index scanning from r_last+1 with wrap modulo NUM_MASTERS.
  - On the next edge: r_grant=that master, state=BUSY. Arbitration latency is 1 cycle.
- BUSY:
  - o_s_cyc=i_m_cyc[g] and o_s_stb=i_m_stb[g], combinational from the granted master g; same for adr/dat/we/sel.
  - o_m_ack[g]=i_s_ack & i_m_stb[g]. Acks never reach non-granted masters.
  - o_m_dat=i_s_dat, unqualified; masters sample it only on their own ack.
  - Grant is held across multiple stb beats for as long as i_m_cyc[g]=1. Other masters' requests are ignored until then.
  - When i_m_cyc[g]=0: r_last=g, r_grant=0, state=IDLE. At least one IDLE cycle between grants; no back-to-back handoff.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each BUSY cycle with o_s_stb=1 and i_s_ack=0.
  - Clears on ack, on stb=0, and in IDLE.
  - When the counter reaches TIMEOUT_CYCLES, state=ERR for exactly one cycle.
- ERR:
  - o_m_err[g]=1, o_s_stb=0, o_s_cyc=1, o_m_ack=0, counter cleared.
  - Next state is BUSY if i_m_cyc[g] is still 1, else IDLE with r_last=g.
  - A late i_s_ack arriving during ERR is dropped.
- Simultaneous events:
  - i_s_ack in the same cycle the counter would hit TIMEOUT_CYCLES: ack wins, no error.
  - Granted master drops cyc in the same cycle as ack: ack still delivered, then IDLE.
- Reset mid-cycle: all outputs drop immediately (async); arbitration restarts from master 0.
- Status outputs:
  - o_grant = r_grant.
  - o_busy=1 in BUSY and ERR.

Test Plan:
- Single master: M0 read 0x1000_0000 with cyc/stb; slave acks 2 cycles after o_s_stb, i_s_dat=0xCAFE_F00D. Expect: grant 1 cycle after cyc; o_m_ack=01; o_m_dat=0xCAFE_F00D; IDLE after cyc drops.
- Contention: M0 and M1 both assert cyc at reset release. Expect: M0 granted first; M1 granted after M0 releases plus 1 IDLE cycle. With both re-requesting, grants alternate 0,1,0,1.
- Burst hold: M1 holds cyc for 4 stb beats while M0 requests. Expect: 4 acks to M1 only; o_m_ack[0]=0 throughout; M0 granted only after M1 cyc=0.
- Timeout: TIMEOUT_CYCLES=8, slave never acks. Expect: o_m_err[g]=1 for one cycle exactly 8 cycles after stb asserts; o_s_stb=0 that cycle. An ack on cycle 8 instead yields an ack with no err.
- Reset mid-transaction: assert i_reset while M1 granted and stb pending. Expect: o_s_cyc/o_s_stb/o_grant/o_m_ack=0 immediately. After release with both requesting, M0 granted first.
- Isolation: slave ack while in IDLE or ERR. Expect: no o_m_ack bit asserted.
